pwr_good_monitor: RTL

- Receive side of the board power-control path: watches regulator power-good returns after the rail enables and sync clocks have been driven.
- Synchronizes and debounces each rail's PG line.
- Tracks the rail sequence: commanded-on, ramp, good, fault.
- Reports readiness and sticky per-rail fault status back to the power controller and system logic.

---
 rtl/pwr_mon_pkg.sv | 23 ++
 rtl/pwr_good_monitor_if.sv | 30 +++
 rtl/pg_debounce.sv | 55 +++++
 rtl/pwr_good_monitor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pwr_mon_pkg.sv
// Shared types and width helpers for the power-good monitor.
package pwr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    GOOD  = 2'd2,
    FAULT = 2'd3
  } mon_state_t;

  // Width of a counter holding values 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEBOUNCE_CYC_DEF = 16;
  localparam int TIMEOUT_CYC_DEF  = 100000;
  localparam int SYNC_MAX_GAP_DEF = 64;
  localparam int DB_W_DEF         = cnt_w(DEBOUNCE_CYC_DEF);
  localparam int TO_W_DEF         = cnt_w(TIMEOUT_CYC_DEF);
  localparam int GAP_W_DEF        = cnt_w(SYNC_MAX_GAP_DEF + 1);

endpackage

// File: rtl/pwr_good_monitor_if.sv
// Monitor <-> power-controller signal bundle.
// PWR_MON_SYNC_CHECK_EN adds sync_in / sync_lost.
interface pwr_good_monitor_if
  import pwr_mon_pkg::*;
#(
  parameter int N_RAILS = 2
) ();
  logic               pwr_en;
  logic [N_RAILS-1:0] pg_in;
  logic               fault_clr;
  logic [N_RAILS-1:0] pg_filt;
  logic               rails_ok;
  logic               fault;
  logic [N_RAILS-1:0] fault_rail;
  mon_state_t         mon_state;
`ifdef PWR_MON_SYNC_CHECK_EN
  logic               sync_in;
  logic               sync_lost;

  modport master (output pwr_en, pg_in, fault_clr, sync_in,
                  input  pg_filt, rails_ok, fault, fault_rail, mon_state, sync_lost);
  modport slave  (input  pwr_en, pg_in, fault_clr, sync_in,
                  output pg_filt, rails_ok, fault, fault_rail, mon_state, sync_lost);
`else
  modport master (output pwr_en, pg_in, fault_clr,
                  input  pg_filt, rails_ok, fault, fault_rail, mon_state);
  modport slave  (input  pwr_en, pg_in, fault_clr,
                  output pg_filt, rails_ok, fault, fault_rail, mon_state);
`endif
endinterface

// File: rtl/pg_debounce.sv
// 2-FF synchronizer followed by either a debounce filter (EDGE_OUT=0)
// or a registered-edge strobe (EDGE_OUT=1) for the sync-clock checker.
module pg_debounce
  import pwr_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter bit EDGE_OUT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic meta;
  logic sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic prev;
      always_ff @(posedge clk) begin
        if (!rst) prev <= 1'b0;
        else      prev <= sync;
      end
      assign dout = sync ^ prev;
    end else begin : g_filt
      localparam int CW = cnt_w(DEBOUNCE_CYC);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
      logic [CW-1:0] cnt;
      // cnt = consecutive samples disagreeing with dout
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt  <= '0;
          dout <= 1'b0;
        end else if (sync == dout) begin
          cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt  <= '0;
          dout <= ~dout;
        end else begin
          cnt  <= cnt + 1'b1;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/pwr_good_monitor.sv
// Debounces per-rail power-good and sequences IDLE/RAMP/GOOD/FAULT.
// PWR_MON_SYNC_CHECK_EN adds a regulator sync-clock loss detector.
module pwr_good_monitor
  import pwr_mon_pkg::*;
#(
  parameter int N_RAILS      = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
`ifdef PWR_MON_SYNC_CHECK_EN
  ,
  parameter int SYNC_MAX_GAP = SYNC_MAX_GAP_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  pwr_good_monitor_if.slave bus
);
  localparam int TO_W = cnt_w(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [N_RAILS-1:0] pg_filt;
  logic [N_RAILS-1:0] fault_rail;
  logic [TO_W-1:0]    tcnt;
  logic               rails_ok;
  logic               fault;
  logic               all_good;
  logic               sync_fault;
  mon_state_t         state;

  generate
    for (genvar i = 0; i < N_RAILS; i++) begin : g_rail
      pg_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .EDGE_OUT(1'b0)) u_pg (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.pg_in[i]),
        .dout (pg_filt[i])
      );
    end
  endgenerate

  assign all_good = &pg_filt;

`ifdef PWR_MON_SYNC_CHECK_EN
  localparam int GAP_W = cnt_w(SYNC_MAX_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SYNC_MAX_GAP);

  logic             sync_edge;
  logic [GAP_W-1:0] gap;
  logic             sync_lost;
  logic             active;

  pg_debounce #(.DEBOUNCE_CYC(2), .EDGE_OUT(1'b1)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.sync_in),
    .dout (sync_edge)
  );

  assign active = (state == RAMP) || (state == GOOD);

  always_ff @(posedge clk) begin
    if (!rst || !active) gap <= '0;
    else if (sync_edge)  gap <= '0;
    else if (gap != GAP_MAX) gap <= gap + 1'b1;
  end

  assign sync_fault = (gap == GAP_MAX);

  // Mirrors the FSM's FAULT entry/exit conditions for the sync cause.
  always_ff @(posedge clk) begin
    if (!rst)
      sync_lost <= 1'b0;
    else if (active && bus.pwr_en && sync_fault)
      sync_lost <= 1'b1;
    else if (state == FAULT && bus.fault_clr && !bus.pwr_en)
      sync_lost <= 1'b0;
  end

  assign bus.sync_lost = sync_lost;
`else
  assign sync_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      rails_ok   <= 1'b0;
      fault      <= 1'b0;
      fault_rail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pwr_en) begin
            state <= RAMP;
            tcnt  <= '0;
          end
        end
        RAMP: begin
          if (tcnt != TO_LAST) tcnt <= tcnt + 1'b1;
          if (!bus.pwr_en) begin
            state <= IDLE;
          end else if (sync_fault) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (all_good) begin
            state    <= GOOD;
            rails_ok <= 1'b1;
          end else if (tcnt == TO_LAST) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_rail <= ~pg_filt;
          end
        end
        GOOD: begin
          if (!bus.pwr_en) begin
            state    <= IDLE;
            rails_ok <= 1'b0;
          end else if (sync_fault) begin
            state    <= FAULT;
            rails_ok <= 1'b0;
            fault    <= 1'b1;
          end else if (!all_good) begin
            state      <= FAULT;
            rails_ok   <= 1'b0;
            fault      <= 1'b1;
            fault_rail <= ~pg_filt;
          end
        end
        FAULT: begin
          if (bus.fault_clr && !bus.pwr_en) begin
            state      <= IDLE;
            fault      <= 1'b0;
            fault_rail <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pg_filt    = pg_filt;
  assign bus.rails_ok   = rails_ok;
  assign bus.fault      = fault;
  assign bus.fault_rail = fault_rail;
  assign bus.mon_state  = state;
endmodule
